// File: rtl/rtr_credit_tracker.sv
// Output-port credit tracker: registers the outgoing flit channel and keeps a
// per-VC count of free downstream slots, exporting full/almost-full/empty/idle.
module rtr_credit_tracker #(
    parameter int num_vcs              = 4,
    parameter int buffer_size          = 32,
    parameter int flit_data_width      = 64,
    parameter int atomic_vc_allocation = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       send_valid,
    input  logic                       send_head,
    input  logic                       send_tail,
    input  logic [num_vcs-1:0]         send_sel_ovc,
    input  logic [flit_data_width-1:0] send_data,
    input  logic                       cred_valid,
    input  logic [num_vcs-1:0]         cred_sel_ovc,
    output logic                       flit_valid,
    output logic                       flit_head,
    output logic                       flit_tail,
    output logic [num_vcs-1:0]         flit_sel_ovc,
    output logic [flit_data_width-1:0] flit_data,
    output logic [num_vcs-1:0]         full_ovc,
    output logic [num_vcs-1:0]         almost_full_ovc,
    output logic [num_vcs-1:0]         empty_ovc,
    output logic [num_vcs-1:0]         idle_ovc,
    output logic [2*num_vcs-1:0]       errors_ovc
);

    localparam int buffer_size_per_vc = buffer_size / num_vcs;
    localparam int cred_width         = $clog2(buffer_size_per_vc + 1);
    localparam logic [cred_width-1:0] cred_max = cred_width'(buffer_size_per_vc);

    logic [num_vcs-1:0]         accept_vec;
    logic [2*num_vcs-1:0]       errors_next;
    logic                       flit_accept;

    logic                       flit_valid_reg;
    logic                       flit_head_reg;
    logic                       flit_tail_reg;
    logic [num_vcs-1:0]         flit_sel_ovc_reg;
    logic [flit_data_width-1:0] flit_data_reg;
    logic [2*num_vcs-1:0]       errors_reg;

    genvar gi;
    generate
        for (gi = 0; gi < num_vcs; gi++) begin : g_vc
            logic [cred_width-1:0] cred_reg;
            logic [cred_width-1:0] cred_next;
            logic                  send_req;
            logic                  cred_req;
            logic                  accept;
            logic                  overflow;

            assign send_req = send_valid & send_sel_ovc[gi];
            assign cred_req = cred_valid & cred_sel_ovc[gi];
            // A send against an empty counter is refused even if a credit arrives alongside it.
            assign accept   = send_req & (cred_reg != '0);
            assign overflow = cred_req & ~accept & (cred_reg == cred_max);

            assign accept_vec[gi]        = accept;
            assign errors_next[2*gi]     = send_req & (cred_reg == '0);
            assign errors_next[2*gi+1]   = overflow;

            always_comb begin
                cred_next = cred_reg;
                if (accept && !cred_req) begin
                    cred_next = cred_reg - 1'b1;
                end else if (cred_req && !accept && !overflow) begin
                    cred_next = cred_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cred_reg <= cred_max;
                end else begin
                    cred_reg <= cred_next;
                end
            end

            assign full_ovc[gi]        = (cred_reg == '0);
            assign almost_full_ovc[gi] = (cred_reg == cred_width'(1));
            assign empty_ovc[gi]       = (cred_reg == cred_max);

            if (atomic_vc_allocation != 0) begin : g_atomic
                logic pending_reg;

                // Tail wins over head so a single-flit packet leaves the VC unowned.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        pending_reg <= 1'b0;
                    end else if (accept) begin
                        if (send_tail) begin
                            pending_reg <= 1'b0;
                        end else if (send_head) begin
                            pending_reg <= 1'b1;
                        end
                    end
                end

                assign idle_ovc[gi] = empty_ovc[gi] & ~pending_reg;
            end else begin : g_plain
                assign idle_ovc[gi] = empty_ovc[gi];
            end
        end
    endgenerate

    assign flit_accept = |accept_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            flit_valid_reg   <= 1'b0;
            flit_head_reg    <= 1'b0;
            flit_tail_reg    <= 1'b0;
            flit_sel_ovc_reg <= '0;
            errors_reg       <= '0;
        end else begin
            flit_valid_reg   <= flit_accept;
            flit_head_reg    <= flit_accept & send_head;
            flit_tail_reg    <= flit_accept & send_tail;
            flit_sel_ovc_reg <= flit_accept ? send_sel_ovc : '0;
            errors_reg       <= errors_next;
        end
    end

    // Payload register is left unreset; it only loads on an accepted send.
    always_ff @(posedge clk) begin
        if (flit_accept) begin
            flit_data_reg <= send_data;
        end
    end

    assign flit_valid   = flit_valid_reg;
    assign flit_head    = flit_head_reg;
    assign flit_tail    = flit_tail_reg;
    assign flit_sel_ovc = flit_sel_ovc_reg;
    assign flit_data    = flit_data_reg;
    assign errors_ovc   = errors_reg;

endmodule

// File: tb/tb_rtr_credit_tracker.sv
// Scoreboard bench for rtr_credit_tracker: a per-VC credit model predicts each
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_rtr_credit_tracker;

    localparam int NV  = 4;
    localparam int MAX = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        send_valid, send_head, send_tail;
    logic [3:0]  send_sel_ovc;
    logic [63:0] send_data;
    logic        cred_valid;
    logic [3:0]  cred_sel_ovc;
    logic        flit_valid, flit_head, flit_tail;
    logic [3:0]  flit_sel_ovc;
    logic [63:0] flit_data;
    logic [3:0]  full_ovc, almost_full_ovc, empty_ovc, idle_ovc;
    logic [7:0]  errors_ovc;

    rtr_credit_tracker #(
        .num_vcs(4), .buffer_size(32), .flit_data_width(64), .atomic_vc_allocation(1)
    ) dut (
        .clk(clk), .reset(reset),
        .send_valid(send_valid), .send_head(send_head), .send_tail(send_tail),
        .send_sel_ovc(send_sel_ovc), .send_data(send_data),
        .cred_valid(cred_valid), .cred_sel_ovc(cred_sel_ovc),
        .flit_valid(flit_valid), .flit_head(flit_head), .flit_tail(flit_tail),
        .flit_sel_ovc(flit_sel_ovc), .flit_data(flit_data),
        .full_ovc(full_ovc), .almost_full_ovc(almost_full_ovc),
        .empty_ovc(empty_ovc), .idle_ovc(idle_ovc), .errors_ovc(errors_ovc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fv;
        logic        fh;
        logic        ft;
        logic [3:0]  fsel;
        logic [63:0] fdata;
        logic        data_known;
        logic [7:0]  err;
        logic [3:0]  full;
        logic [3:0]  af;
        logic [3:0]  empty;
        logic [3:0]  idle;
    } exp_t;

    exp_t        exp_q[$];
    int          num_checks = 0;
    int          num_errors = 0;
    int          txn = 0;
    int          m_cnt[NV];
    bit          m_pend[NV];
    logic [63:0] m_data;
    bit          m_have_data = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_underrun", 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check_eq("flit_valid", 64'(flit_valid), 64'(e.fv));
        check_eq("flit_head", 64'(flit_head), 64'(e.fh));
        check_eq("flit_tail", 64'(flit_tail), 64'(e.ft));
        check_eq("flit_sel_ovc", 64'(flit_sel_ovc), 64'(e.fsel));
        if (e.data_known) check_eq("flit_data", flit_data, e.fdata);
        check_eq("errors_ovc", 64'(errors_ovc), 64'(e.err));
        check_eq("full_ovc", 64'(full_ovc), 64'(e.full));
        check_eq("almost_full_ovc", 64'(almost_full_ovc), 64'(e.af));
        check_eq("empty_ovc", 64'(empty_ovc), 64'(e.empty));
        check_eq("idle_ovc", 64'(idle_ovc), 64'(e.idle));
    endtask

    function automatic exp_t status_from_model();
        exp_t e;
        e = '0;
        for (int v = 0; v < NV; v++) begin
            e.full[v]  = (m_cnt[v] == 0);
            e.af[v]    = (m_cnt[v] == 1);
            e.empty[v] = (m_cnt[v] == MAX);
            e.idle[v]  = (m_cnt[v] == MAX) && !m_pend[v];
        end
        e.fdata      = m_data;
        e.data_known = m_have_data;
        return e;
    endfunction

    task automatic step(input logic sv, input logic sh, input logic st, input logic [3:0] ssel,
                        input logic [63:0] sd, input logic cv, input logic [3:0] csel);
        exp_t       e;
        logic [7:0] err;
        bit         any_acc;
        send_valid = sv; send_head = sh; send_tail = st; send_sel_ovc = ssel; send_data = sd;
        cred_valid = cv; cred_sel_ovc = csel;
        err = '0;
        any_acc = 0;
        for (int v = 0; v < NV; v++) begin
            bit s, c, acc;
            s = sv && ssel[v];
            c = cv && csel[v];
            acc = 0;
            if (s && m_cnt[v] == 0) err[2*v] = 1'b1;
            else if (s) acc = 1;
            if (c && !acc && m_cnt[v] == MAX) err[2*v+1] = 1'b1;
            if (acc && !c) m_cnt[v] = m_cnt[v] - 1;
            else if (c && !acc && m_cnt[v] < MAX) m_cnt[v] = m_cnt[v] + 1;
            if (acc) begin
                if (st) m_pend[v] = 0;
                else if (sh) m_pend[v] = 1;
                any_acc = 1;
            end
        end
        if (any_acc) begin
            m_data = sd;
            m_have_data = 1;
        end
        e = status_from_model();
        e.err  = err;
        e.fv   = any_acc;
        e.fh   = any_acc && sh;
        e.ft   = any_acc && st;
        e.fsel = any_acc ? ssel : 4'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d: send v=%0b h=%0b t=%0b sel=%b cred v=%0b sel=%b -> flit_valid=%0b err=%b full=%b idle=%b",
                 txn, sv, sh, st, ssel, cv, csel, flit_valid, errors_ovc, full_ovc, idle_ovc);
        compare_out();
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 4'b0, 64'd0, 1'b0, 4'b0);
    endtask

    task automatic do_reset();
        exp_t e;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int v = 0; v < NV; v++) begin
            m_cnt[v]  = MAX;
            m_pend[v] = 0;
        end
        check_eq("rst_empty", 64'(empty_ovc), 64'hf);
        check_eq("rst_idle", 64'(idle_ovc), 64'hf);
        check_eq("rst_full", 64'(full_ovc), 64'h0);
        check_eq("rst_almost_full", 64'(almost_full_ovc), 64'h0);
        check_eq("rst_flit_valid", 64'(flit_valid), 64'h0);
        check_eq("rst_flit_sel", 64'(flit_sel_ovc), 64'h0);
        check_eq("rst_errors", 64'(errors_ovc), 64'h0);
        e = status_from_model();
        e.err = '0; e.fv = 0; e.fh = 0; e.ft = 0; e.fsel = '0;
        exp_q.push_back(e);
        compare_out();
    endtask

    initial begin
        reset = 1'b1;
        send_valid = 0; send_head = 0; send_tail = 0; send_sel_ovc = '0; send_data = '0;
        cred_valid = 0; cred_sel_ovc = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Drain VC 2 with eight back-to-back sends.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, 1'b0, 4'b0100, 64'hA200 + 64'(i), 1'b0, 4'b0);
            check_eq("drain_flit_sel", 64'(flit_sel_ovc), 64'h4);
            if (i == 6) check_eq("af2_after7", 64'(almost_full_ovc[2]), 64'd1);
            if (i == 7) check_eq("full2_after8", 64'(full_ovc[2]), 64'd1);
        end
        step(1'b1, 1'b0, 1'b0, 4'b0100, 64'hDEAD, 1'b0, 4'b0);
        check_eq("underflow_no_flit", 64'(flit_valid), 64'd0);
        check_eq("underflow_err4", 64'(errors_ovc[4]), 64'd1);
        idle_step();
        check_eq("underflow_err_pulse", 64'(errors_ovc), 64'd0);
        check_eq("full2_stays", 64'(full_ovc[2]), 64'd1);

        // VC 0: bring count to 5, then send+credit together.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'b0001, 64'hB000 + 64'(i), 1'b0, 4'b0);
        step(1'b1, 1'b0, 1'b0, 4'b0001, 64'hB0B0, 1'b1, 4'b0001);
        check_eq("sc5_flit", 64'(flit_valid), 64'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 4'b0001, 64'hC000 + 64'(i), 1'b0, 4'b0);
        check_eq("vc0_full", 64'(full_ovc[0]), 64'd1);
        step(1'b1, 1'b0, 1'b0, 4'b0001, 64'hBAD0, 1'b1, 4'b0001);
        check_eq("sc0_no_flit", 64'(flit_valid), 64'd0);
        check_eq("sc0_err0", 64'(errors_ovc[0]), 64'd1);
        check_eq("sc0_full_drop", 64'(full_ovc[0]), 64'd0);

        // Credit overflow on VC 1.
        step(1'b0, 1'b0, 1'b0, 4'b0, 64'd0, 1'b1, 4'b0010);
        check_eq("ovf_err3", 64'(errors_ovc[3]), 64'd1);
        idle_step();
        check_eq("ovf_empty1", 64'(empty_ovc[1]), 64'd1);

        // Packet tracking on VC 3.
        step(1'b1, 1'b1, 1'b0, 4'b1000, 64'h3001, 1'b0, 4'b0);
        step(1'b1, 1'b0, 1'b0, 4'b1000, 64'h3002, 1'b0, 4'b0);
        step(1'b1, 1'b0, 1'b1, 4'b1000, 64'h3003, 1'b0, 4'b0);
        check_eq("pkt_tail_flag", 64'(flit_tail), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'b0, 64'd0, 1'b1, 4'b1000);
            check_eq("pkt_idle3", 64'(idle_ovc[3]), (i == 2) ? 64'd1 : 64'd0);
        end
        step(1'b1, 1'b1, 1'b1, 4'b1000, 64'h3004, 1'b0, 4'b0);
        check_eq("single_idle3_busy", 64'(idle_ovc[3]), 64'd0);
        step(1'b0, 1'b0, 1'b0, 4'b0, 64'd0, 1'b1, 4'b1000);
        check_eq("single_idle3_back", 64'(idle_ovc[3]), 64'd1);

        // Randomised traffic including zero selects, overflows and underflows.
        for (int i = 0; i < 200; i++) begin
            int          si, ci;
            logic [3:0]  ssel, csel;
            logic [31:0] r;
            si = $urandom_range(0, 4);
            ci = $urandom_range(0, 4);
            ssel = (si == 4) ? 4'b0 : 4'(1 << si);
            csel = (ci == 4) ? 4'b0 : 4'(1 << ci);
            r = $urandom;
            step(r[0] | r[1], r[2], r[3], ssel, {$urandom, $urandom}, r[4], csel);
        end

        // Reset in the middle of a packet on VC 1.
        step(1'b1, 1'b1, 1'b0, 4'b0010, 64'h1111, 1'b0, 4'b0);
        do_reset();
        check_eq("midpkt_idle1", 64'(idle_ovc[1]), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
